// File: rtl/result_packer_if.sv
// Handshake and data bundle for result_packer.
//   in_valid/in_ready + result_* : upstream result (sign, exponent, fraction MSB, low fraction, flags)
//   out_valid/out_ready + out_*  : packed IEEE-754 single word and its flags
// slave  : view used by result_packer itself
// master : view used by whatever drives and consumes the stage
interface result_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        result_sign;
  logic [7:0]  result_exponent;
  logic        result_22;
  logic [21:0] result_fraction_low;
  logic [4:0]  result_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  modport slave (
    input  in_valid, result_sign, result_exponent, result_22, result_fraction_low,
           result_flags, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, result_sign, result_exponent, result_22, result_fraction_low,
           result_flags, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/result_packer.sv
// FPU output stage: packs {sign, exponent, fraction MSB, fraction low} into an IEEE-754 single
// word and registers it behind a valid/ready handshake with a 2-entry skid buffer.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus           : result_packer_if.slave (input result + handshake, output word + handshake)
//   flag_clear    : clears sticky_flags (flags of a word transferring the same cycle survive)
//   sticky_flags  : OR of out_flags over all output transfers since the last clear
//   result_count  : number of output transfers, wrapping
module result_packer #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  result_packer_if.slave         bus,
  input  logic                   flag_clear,
  output logic [4:0]             sticky_flags,
  output logic [COUNT_WIDTH-1:0] result_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            main_data_q, skid_data_q;
  logic [4:0]             main_flags_q, skid_flags_q;
  logic                   in_ready_q;
  logic [4:0]             sticky_q, sticky_d;
  logic [COUNT_WIDTH-1:0] count_q;

  logic        in_xfer, out_xfer;
  logic        load_main, load_skid, skid_to_main;
  logic [31:0] packed_word;

  assign packed_word = {bus.result_sign, bus.result_exponent, bus.result_22,
                        bus.result_fraction_low};

  assign bus.out_valid  = (state_q != StEmpty);
  assign bus.in_ready   = in_ready_q;
  assign bus.out_result = main_data_q;
  assign bus.out_flags  = main_flags_q;
  assign sticky_flags   = sticky_q;
  assign result_count   = count_q;

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = StFull;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so no input can arrive alongside the drain.
        if (out_xfer) begin
          skid_to_main = 1'b1;
          state_d      = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Clear first, then OR in the transferring word so its flags survive a coincident clear.
  always_comb begin
    sticky_d = flag_clear ? 5'b0 : sticky_q;
    if (out_xfer) begin
      sticky_d = sticky_d | main_flags_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEmpty;
      main_data_q  <= '0;
      main_flags_q <= '0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      in_ready_q   <= 1'b1;
      sticky_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
      sticky_q   <= sticky_d;
      if (out_xfer) begin
        count_q <= count_q + 1'b1;
      end
      if (load_main) begin
        main_data_q  <= packed_word;
        main_flags_q <= bus.result_flags;
      end else if (skid_to_main) begin
        main_data_q  <= skid_data_q;
        main_flags_q <= skid_flags_q;
      end
      if (load_skid) begin
        skid_data_q  <= packed_word;
        skid_flags_q <= bus.result_flags;
      end
    end
  end

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flag_clear;
  logic [4:0]  sticky16, sticky4;
  logic [15:0] count16;
  logic [3:0]  count4;

  result_packer_if pif ();
  result_packer_if pif4 ();

  always #5 clk = ~clk;

  // Second instance with a 4-bit counter sees identical stimulus.
  assign pif4.in_valid            = pif.in_valid;
  assign pif4.result_sign         = pif.result_sign;
  assign pif4.result_exponent     = pif.result_exponent;
  assign pif4.result_22           = pif.result_22;
  assign pif4.result_fraction_low = pif.result_fraction_low;
  assign pif4.result_flags        = pif.result_flags;
  assign pif4.out_ready           = pif.out_ready;

  result_packer #(.COUNT_WIDTH(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (pif),
    .flag_clear   (flag_clear),
    .sticky_flags (sticky16),
    .result_count (count16)
  );

  result_packer #(.COUNT_WIDTH(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .bus          (pif4),
    .flag_clear   (flag_clear),
    .sticky_flags (sticky4),
    .result_count (count4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a FIFO of capacity 2 holding {word, flags}; head is what the output shows.
  logic [36:0] q[$];
  logic [4:0]  m_sticky;
  int unsigned m_count;
  bit          m_in_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sticky   = '0;
    m_count    = 0;
    m_in_ready = 1'b1;
  endtask

  // One clock: compare on the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit ix, ox;
    @(negedge clk);
    check_eq("out_valid", {31'b0, pif.out_valid}, {31'b0, q.size() > 0});
    check_eq("in_ready", {31'b0, pif.in_ready}, {31'b0, m_in_ready});
    if (q.size() > 0) begin
      check_eq("out_result", pif.out_result, q[0][36:5]);
      check_eq("out_flags", {27'b0, pif.out_flags}, {27'b0, q[0][4:0]});
    end
    check_eq("sticky", {27'b0, sticky16}, {27'b0, m_sticky});
    check_eq("count16", {16'b0, count16}, m_count % 65536);
    check_eq("count4", {28'b0, count4}, m_count % 16);
    check_eq("v4_match", {31'b0, pif4.out_valid}, {31'b0, q.size() > 0});
    ix = pif.in_valid && m_in_ready;
    ox = (q.size() > 0) && pif.out_ready;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (ox) begin
        m_sticky = (flag_clear ? 5'b0 : m_sticky) | q[0][4:0];
        m_count++;
        void'(q.pop_front());
      end else if (flag_clear) begin
        m_sticky = '0;
      end
      if (ix) begin
        q.push_back({pif.result_sign, pif.result_exponent, pif.result_22,
                     pif.result_fraction_low, pif.result_flags});
      end
      m_in_ready = (q.size() < 2);
    end
    #1;
  endtask

  task automatic rand_data();
    pif.result_sign         = 1'($urandom);
    pif.result_exponent     = 8'($urandom);
    pif.result_22           = 1'($urandom);
    pif.result_fraction_low = 22'($urandom);
    pif.result_flags        = 5'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [31:0] word_a;

  initial begin
    reset          = 1'b1;
    flag_clear     = 1'b0;
    pif.in_valid   = 1'b0;
    pif.out_ready  = 1'b0;
    rand_data();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset values
    check_eq("rst_out_valid", {31'b0, pif.out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, pif.in_ready}, 32'd1);
    check_eq("rst_out_result", pif.out_result, 32'd0);
    check_eq("rst_out_flags", {27'b0, pif.out_flags}, 32'd0);

    // Single word
    pif.result_sign = 1'b1; pif.result_exponent = 8'h80; pif.result_22 = 1'b1;
    pif.result_fraction_low = 22'h000001; pif.result_flags = 5'b00001;
    pif.in_valid = 1'b1; pif.out_ready = 1'b1;
    step();
    pif.in_valid = 1'b0;
    check_eq("single_result", pif.out_result, 32'hC0400001);
    check_eq("single_valid", {31'b0, pif.out_valid}, 32'd1);
    step();
    check_eq("single_sticky", {27'b0, sticky16}, 32'd1);
    check_eq("single_count", {16'b0, count16}, 32'd1);

    // Backpressure: A, B, C with out_ready low
    pif.out_ready = 1'b0;
    pif.in_valid  = 1'b1;
    rand_data();
    word_a = {pif.result_sign, pif.result_exponent, pif.result_22, pif.result_fraction_low};
    step();
    rand_data();
    step();
    rand_data();
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_in_ready_low", {31'b0, pif.in_ready}, 32'd0);
      check_eq("bp_main_holds_a", pif.out_result, word_a);
      step();
    end
    pif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit acc;
      acc = m_in_ready;
      step();
      if (acc) begin
        pif.in_valid = 1'b0;
        break;
      end
    end
    check_eq("bp_c_accepted", {31'b0, pif.in_valid}, 32'd0);
    repeat (4) step();

    // Streaming 100 words
    do_reset();
    pif.out_ready = 1'b1;
    pif.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_data();
      step();
    end
    pif.in_valid = 1'b0;
    step();
    check_eq("stream_count", {16'b0, count16}, 32'd100);
    check_eq("stream_count4", {28'b0, count4}, 32'd4);

    // Flag clear colliding with a transfer
    do_reset();
    rand_data();
    pif.result_flags = 5'b10000;
    pif.in_valid = 1'b1;
    step();
    rand_data();
    pif.result_flags = 5'b00100;
    step();
    pif.in_valid = 1'b0;
    check_eq("clr_pre_sticky", {27'b0, sticky16}, 32'b10000);
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    check_eq("clr_collision", {27'b0, sticky16}, 32'b00100);

    // Counter wrap on the 4-bit instance
    do_reset();
    pif.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_data();
      step();
    end
    pif.in_valid = 1'b0;
    step();
    check_eq("wrap_count4", {28'b0, count4}, 32'd1);
    check_eq("wrap_count16", {16'b0, count16}, 32'd17);

    // Reset while FULL
    pif.out_ready = 1'b0;
    pif.in_valid  = 1'b1;
    repeat (3) begin
      rand_data();
      step();
    end
    pif.in_valid = 1'b0;
    check_eq("full_before_rst", {31'b0, pif.in_ready}, 32'd0);
    do_reset();
    check_eq("frst_out_valid", {31'b0, pif.out_valid}, 32'd0);
    check_eq("frst_in_ready", {31'b0, pif.in_ready}, 32'd1);
    check_eq("frst_sticky", {27'b0, sticky16}, 32'd0);
    check_eq("frst_count", {16'b0, count16}, 32'd0);
    pif.out_ready = 1'b1;
    repeat (4) step();

    // Random mix
    for (int i = 0; i < 400; i++) begin
      rand_data();
      pif.in_valid  = 1'($urandom_range(0, 3) != 0);
      pif.out_ready = 1'($urandom_range(0, 2) != 0);
      flag_clear    = ($urandom_range(0, 15) == 0);
      step();
    end
    flag_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/result_packer.md
# result_packer

Output stage of the pipelined FPU, directly downstream of the result fraction MSB selection. It packs the final sign, biased exponent, selected fraction MSB (bit 22) and the remaining fraction bits [21:0] into an IEEE-754 single-precision word. It registers the word behind a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops a result. It also keeps sticky exception flags and a completed-result counter.

## Interface
Parameters:
- COUNT_WIDTH, 16, width of the completed-result counter.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Reset is synchronous and active-high.
- in_valid  input  1  Upstream has a result this cycle.
- in_ready  output  1  Stage can accept; registered.
- result_sign  input  1  Final sign.
- result_exponent  input  8  Final biased exponent.
- result_22  input  1  Fraction MSB from the fraction MSB selecter.
- result_fraction_low  input  22  Fraction bits [21:0].
- result_flags  input  5  {invalid, div_by_zero, overflow, underflow, inexact} for this result.
- out_valid  output  1  out_result holds a valid word.
- out_ready  input  1  Downstream accepts.
- out_result  output  32  {sign, exponent[7:0], result_22, fraction_low[21:0]}.
- out_flags  output  5  Flags travelling with out_result.
- sticky_flags  output  5  OR of out_flags over all output transfers since the last clear.
- flag_clear  input  1  Clears sticky_flags.
- result_count  output  COUNT_WIDTH  Number of output transfers, mod 2^COUNT_WIDTH.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Packing is purely bit concatenation. No rounding, normalisation or special-case handling is done here.
- Storage consists of a main register (drives out_result/out_flags, with valid bit = out_valid) and a skid register (with valid bit skid_valid).
- in_ready = !skid_valid, registered.
- Per-cycle rules:
  - Input transfer, main empty or output transfer this cycle, skid empty: the word loads into main.
  - Input transfer, main full and no output transfer: the word loads into skid, and skid_valid is set.
  - Output transfer with skid full: skid moves to main and skid_valid clears. If an input transfer happens in the same cycle, that is impossible because in_ready=0.
  - Output transfer, skid empty, no input: out_valid clears.
- The states are EMPTY (main 0, skid 0), ONE (1,0) and FULL (1,1). No other encoding is reachable.
  - EMPTY to ONE on input.
  - ONE to FULL on input without output.
  - ONE stays ONE on input with output.
  - ONE to EMPTY on output without input.
  - FULL to ONE on output.
- Ordering is strictly FIFO. Words are never dropped or duplicated.
- sticky_flags:
  - On an output transfer, sticky_flags <= (flag_clear ? 0 : sticky_flags) | out_flags.
  - Otherwise, flag_clear sets it to 0.
  - When clear and transfer coincide, the transferring word's flags survive.
- result_count increments by 1 on each output transfer and wraps from all-ones to 0.
- Upstream data is sampled only on an input transfer. It is ignored when in_ready=0.

## Timing
- Reset values: out_valid 0, in_ready 1, skid_valid 0, out_result 0, out_flags 0, sticky_flags 0, result_count 0.
- Reset mid-operation discards both buffered words on the next edge, without an output transfer.
- Latency: 1 cycle from input transfer to out_valid when empty. Throughput is 1 word/cycle while out_ready=1.
- in_ready falls the cycle after the skid fills. It rises the cycle after skid drains.
- out_result and out_flags are stable while out_valid=1 and out_ready=0.
- sticky_flags and result_count reflect a transfer on the edge that completes it (visible next cycle).

## Test plan
- Single word: sign=1, exp=0x80, result_22=1, low=0x000001, flags=5'b00001, out_ready=1.
  - Required: one cycle later out_result=0xC0400001 and out_valid=1.
  - Required next cycle: sticky_flags=5'b00001 and result_count=1.
- Backpressure: push words A, B, C back-to-back with out_ready=0.
  - Required: A held in main, B in skid, in_ready=0 from cycle 3, C not accepted until it is re-presented.
  - Then raise out_ready: the output sequence is A, B, C with no gaps after the first.
- Streaming: 100 random words with out_ready=1 and in_valid=1.
  - Required: outputs match inputs in order, throughput 1/cycle, result_count=100.
- Flag clear collision: sticky=5'b10000, then in one cycle flag_clear=1 while transferring a word with flags=5'b00100.
  - Required: sticky=5'b00100.
- Counter wrap: COUNT_WIDTH=4, 17 transfers.
  - Required: result_count=1.
- Reset in FULL state: assert reset for 1 cycle.
  - Required: out_valid=0, in_ready=1, sticky=0, count=0.
  - No stale word appears afterwards.
